// File: rtl/sprite_regs_pkg.sv
// Shared constants for the sprite/score display-register update sequencer:
// entry count, FSM states and the power-on sprite position table.
`timescale 1ns/1ps
package sprite_regs_pkg;

    localparam int NUM_POS     = 12;
    localparam int NUM_DIGITS  = 3;
    localparam int NUM_ENTRIES = NUM_POS + NUM_DIGITS;

    localparam logic [3:0] FIRST_DIGIT_INDEX = 4'(NUM_POS);
    localparam logic [3:0] LAST_INDEX        = 4'(NUM_ENTRIES - 1);
    localparam logic [8:0] POS_ADDR_BASE     = 9'd0;
    localparam logic [8:0] SCORE_ADDR_DEF    = 9'd12;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } seq_state_e;

    function automatic logic [7:0] pos_default(input logic [3:0] idx);
        logic [7:0] val;
        case (idx)
            4'd0:    val = 8'd100;
            4'd1:    val = 8'd100;
            4'd2:    val = 8'd200;
            4'd3:    val = 8'd150;
            4'd4:    val = 8'd44;
            4'd5:    val = 8'd200;
            4'd6:    val = 8'd244;
            4'd7:    val = 8'd100;
            4'd8:    val = 8'd100;
            4'd9:    val = 8'd4;
            4'd10:   val = 8'd160;
            4'd11:   val = 8'd192;
            default: val = 8'd0;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/bcd_counter3.sv
// Three-digit BCD score counter with clear/tick priority, wrap pulse and
// per-digit change flags so the sequencer marks only changed digits dirty.
`timescale 1ns/1ps
module bcd_counter3
    import sprite_regs_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic        clear,
    output logic [11:0] bcd,
    output logic        wrap,
    output logic [2:0]  digit_chg
);

    logic [11:0] bcd_r;
    logic        wrap_r;
    logic [11:0] bcd_next_s;
    logic        wrap_next_s;
    logic        carry_s;

    // Next score value: clear beats tick, tick ripples a carry through the digits
    always_comb begin
        bcd_next_s  = bcd_r;
        wrap_next_s = 1'b0;
        carry_s     = 1'b0;
        digit_chg   = 3'b000;
        if (clear) begin
            bcd_next_s = 12'd0;
        end else if (tick) begin
            carry_s = 1'b1;
            for (int d = 0; d < NUM_DIGITS; d++) begin
                if (carry_s) begin
                    if (bcd_r[d*4 +: 4] == 4'd9) begin
                        bcd_next_s[d*4 +: 4] = 4'd0;
                        carry_s              = 1'b1;
                    end else begin
                        bcd_next_s[d*4 +: 4] = bcd_r[d*4 +: 4] + 4'd1;
                        carry_s              = 1'b0;
                    end
                end else begin
                    carry_s = 1'b0;
                end
            end
            wrap_next_s = carry_s;
        end else begin
            bcd_next_s = bcd_r;
        end
        for (int d = 0; d < NUM_DIGITS; d++) begin
            digit_chg[d] = (bcd_next_s[d*4 +: 4] != bcd_r[d*4 +: 4]);
        end
    end

    // Score and wrap-pulse registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bcd_r  <= 12'd0;
            wrap_r <= 1'b0;
        end else begin
            bcd_r  <= bcd_next_s;
            wrap_r <= wrap_next_s;
        end
    end

    assign bcd  = bcd_r;
    assign wrap = wrap_r;

endmodule

// File: rtl/sprite_update_seq.sv
// Shadow-register flusher: on each vertical-sync fall, walks the 15 shadow
// entries and writes only the dirty ones to the display register port.
`timescale 1ns/1ps
module sprite_update_seq
    import sprite_regs_pkg::*;
#(
    parameter int NUM_POS_REGS = 12,
    parameter int SCORE_BASE   = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        host_write,
    input  logic [3:0]  host_addr,
    input  logic [7:0]  host_wdata,
    input  logic        score_tick,
    input  logic        score_clear,
    input  logic        vga_vs_n,
    output logic        chipselect,
    output logic        write,
    output logic [8:0]  address,
    output logic [31:0] writedata,
    output logic        busy,
    output logic        flush_done,
    output logic [11:0] score_bcd,
    output logic        score_wrap
);

    localparam logic [3:0] POS_LIMIT  = 4'((NUM_POS_REGS < NUM_POS) ? NUM_POS_REGS : NUM_POS);
    localparam logic [8:0] SCORE_ADDR = 9'(SCORE_BASE);

    seq_state_e             state_r, state_next_s;
    logic [3:0]             idx_r;
    logic                   vs_r, vs_prev_r;
    logic [7:0]             pos_r [NUM_POS];
    logic [NUM_ENTRIES-1:0] dirty_r, dirty_next_s;
    logic [NUM_ENTRIES-1:0] clr_mask_s, set_mask_s;
    logic                   cs_r, busy_r, done_r;
    logic [8:0]             addr_r;
    logic [31:0]            wdata_r;

    logic                   fall_s, last_s, scan_s, eval_dirty_s, host_valid_s;
    logic [7:0]             eval_data_s;
    logic [8:0]             eval_addr_s;
    logic [11:0]            score_s;
    logic [2:0]             digit_chg_s;
    logic                   wrap_s;

    bcd_counter3 u_score (
        .clk       (clk),
        .reset     (reset),
        .tick      (score_tick),
        .clear     (score_clear),
        .bcd       (score_s),
        .wrap      (wrap_s),
        .digit_chg (digit_chg_s)
    );

    // Scan sequencing: start on a registered vsync fall, stop after the last entry
    always_comb begin
        state_next_s = state_r;
        fall_s       = vs_prev_r & ~vs_r;
        last_s       = (idx_r == LAST_INDEX);
        scan_s       = (state_r == ST_SCAN);
        case (state_r)
            ST_IDLE: begin
                if (fall_s) state_next_s = ST_SCAN;
                else        state_next_s = ST_IDLE;
            end
            ST_SCAN: begin
                if (last_s) state_next_s = ST_IDLE;
                else        state_next_s = ST_SCAN;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Entry under evaluation and the dirty-bit update; a same-cycle set beats the clear
    always_comb begin
        host_valid_s = host_write && (host_addr < POS_LIMIT);
        eval_dirty_s = scan_s && dirty_r[idx_r];
        if (idx_r >= FIRST_DIGIT_INDEX) begin
            eval_data_s = {4'd0, score_s[(idx_r - FIRST_DIGIT_INDEX)*4 +: 4]};
            eval_addr_s = SCORE_ADDR + {5'd0, idx_r - FIRST_DIGIT_INDEX};
        end else begin
            eval_data_s = pos_r[idx_r];
            eval_addr_s = POS_ADDR_BASE + {5'd0, idx_r};
        end
        clr_mask_s   = eval_dirty_s ? (15'd1 << idx_r) : 15'd0;
        set_mask_s   = (host_valid_s ? (15'd1 << host_addr) : 15'd0) | {digit_chg_s, 12'd0};
        dirty_next_s = (dirty_r & ~clr_mask_s) | set_mask_s;
    end

    // Control state, vsync samples, dirty bits and the registered display port
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            idx_r     <= 4'd0;
            vs_r      <= 1'b1;
            vs_prev_r <= 1'b1;
            dirty_r   <= {NUM_ENTRIES{1'b1}};
            cs_r      <= 1'b0;
            addr_r    <= 9'd0;
            wdata_r   <= 32'd0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            vs_r      <= vga_vs_n;
            vs_prev_r <= vs_r;
            dirty_r   <= dirty_next_s;
            if (scan_s && !last_s) idx_r <= idx_r + 4'd1;
            else                   idx_r <= 4'd0;
            cs_r      <= eval_dirty_s;
            addr_r    <= eval_dirty_s ? eval_addr_s : 9'd0;
            wdata_r   <= eval_dirty_s ? {24'd0, eval_data_s} : 32'd0;
            busy_r    <= (state_next_s == ST_SCAN) || scan_s;
            done_r    <= scan_s && last_s;
        end
    end

    // Host-owned sprite positions
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_POS; i++) pos_r[i] <= pos_default(4'(i));
        end else if (host_valid_s) begin
            pos_r[host_addr] <= host_wdata;
        end
    end

    assign chipselect = cs_r;
    assign write      = cs_r;
    assign address    = addr_r;
    assign writedata  = wdata_r;
    assign busy       = busy_r;
    assign flush_done = done_r;
    assign score_bcd  = score_s;
    assign score_wrap = wrap_s;

endmodule
